// File: rtl/udma_ptp_ts_pkg.sv
// ---------------------------------------------------------------------------
// udma_ptp_ts_pkg
// Shared definitions for the PTP timestamp record arbiter/serializer:
//   - ts_state_t     : serializer FSM states (IDLE, HDR, W0, W1, W2)
//   - MAGIC_DEFAULT  : default constant placed in header bits [31:24]
//   - HDR_* positions: header field layout
//   - build_hdr()    : assembles a header word from its fields
// ---------------------------------------------------------------------------
package udma_ptp_ts_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_W0   = 3'd2,
        ST_W1   = 3'd3,
        ST_W2   = 3'd4
    } ts_state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    localparam int WORD_W = 32;
    localparam int REC_W  = 96;
    localparam int SEQ_W  = 8;
    localparam int N_SRC  = 2;

    // Header layout: {MAGIC[31:24], 8'h00, src_id[15], 7'h00, seq[7:0]}
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_SRC_BIT   = 15;
    localparam int HDR_SEQ_LSB   = 0;

    function automatic logic [WORD_W-1:0] build_hdr(
        input logic [7:0]       magic,
        input logic             src_id,
        input logic [SEQ_W-1:0] seq
    );
        logic [WORD_W-1:0] hdr;
        hdr                           = '0;
        hdr[HDR_MAGIC_LSB +: 8]       = magic;
        hdr[HDR_SRC_BIT]              = src_id;
        hdr[HDR_SEQ_LSB +: SEQ_W]     = seq;
        return hdr;
    endfunction

endpackage

// File: rtl/udma_ptp_ts_rr_arb.sv
// ---------------------------------------------------------------------------
// udma_ptp_ts_rr_arb
// Two-requester round-robin arbiter with a one-hot grant.
//   clk       in   clock
//   srst      in   synchronous active-high reset
//   i_req     in   [1:0] request vector
//   i_accept  in   grant was consumed this cycle; advance the pointer
//   o_grant   out  [1:0] one-hot grant (combinational from i_req and pointer)
// ---------------------------------------------------------------------------
module udma_ptp_ts_rr_arb
    import udma_ptp_ts_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    // Remembers which source was granted last; 1 means src1 was last,
    // so src0 is preferred. Reset value gives src0 priority.
    logic r_last_src;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        case (i_req)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_src ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_last_src <= 1'b1;
        end else if (i_accept) begin
            r_last_src <= w_grant[1];
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/udma_ptp_ts_arb.sv
// ---------------------------------------------------------------------------
// udma_ptp_ts_arb
// Arbitrates between two 96-bit PTP timestamp sources (RX = src0, TX = src1)
// and serializes the winning record as four 32-bit AXIS beats:
// header, data[31:0], data[63:32], data[95:64] (m_tlast on the last).
//   clk_eth        in   sole clock
//   rst_eth        in   synchronous active-high reset
//   cfg_src_en_i   in   [1:0] per-source enable (bit0 src0, bit1 src1)
//   s0_tdata/s0_tvalid/s0_tready   src0 record input (AXIS)
//   s1_tdata/s1_tvalid/s1_tready   src1 record input (AXIS)
//   m_tdata/m_tvalid/m_tready/m_tlast  32-bit serialized output (AXIS)
//   busy_o         out  high while a record is held (FSM not IDLE)
// ---------------------------------------------------------------------------
module udma_ptp_ts_arb
    import udma_ptp_ts_pkg::*;
#(
    parameter logic [7:0] MAGIC = MAGIC_DEFAULT
) (
    input  logic              clk_eth,
    input  logic              rst_eth,
    input  logic [1:0]        cfg_src_en_i,
    input  logic [REC_W-1:0]  s0_tdata,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic [REC_W-1:0]  s1_tdata,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    output logic [WORD_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy_o
);

    ts_state_t          r_state;
    logic [REC_W-1:0]   r_data;
    logic [WORD_W-1:0]  r_m_tdata;
    logic               r_m_tvalid;
    logic               r_m_tlast;
    logic [SEQ_W-1:0]   r_seq [N_SRC];

    logic [N_SRC-1:0]   w_valid;
    logic [N_SRC-1:0]   w_req;
    logic [N_SRC-1:0]   w_grant;
    logic [N_SRC-1:0]   w_tready;
    logic [N_SRC-1:0]   w_accept;
    logic               w_any_accept;
    logic               w_idle;
    logic               w_beat;
    logic [REC_W-1:0]   w_sel_tdata;
    logic [SEQ_W-1:0]   w_sel_seq;

    assign w_valid = {s1_tvalid, s0_tvalid};
    assign w_idle  = (r_state == ST_IDLE);
    assign w_beat  = r_m_tvalid & m_tready;

    // Per-source request gating, handshake and sequence counters.
    // tready is also masked by reset so nothing is offered while the
    // FSM state may still be undefined.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign w_req[gi]    = w_valid[gi] & cfg_src_en_i[gi];
            assign w_tready[gi] = w_idle & w_grant[gi] & ~rst_eth;
            assign w_accept[gi] = w_tready[gi] & w_valid[gi];

            always_ff @(posedge clk_eth) begin
                if (rst_eth) begin
                    r_seq[gi] <= '0;
                end else if (w_accept[gi]) begin
                    r_seq[gi] <= r_seq[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign w_any_accept = |w_accept;
    assign w_sel_tdata  = w_grant[1] ? s1_tdata : s0_tdata;
    assign w_sel_seq    = w_grant[1] ? r_seq[1] : r_seq[0];

    udma_ptp_ts_rr_arb u_rr_arb (
        .clk      (clk_eth),
        .srst     (rst_eth),
        .i_req    (w_req),
        .i_accept (w_any_accept),
        .o_grant  (w_grant)
    );

    // Serializer FSM. The output word is loaded one cycle ahead of its
    // beat so m_tdata/m_tlast come straight from registers and hold
    // naturally while m_tready is low.
    always_ff @(posedge clk_eth) begin
        if (rst_eth) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_accept) begin
                        r_data     <= w_sel_tdata;
                        r_m_tdata  <= build_hdr(MAGIC, w_grant[1], w_sel_seq);
                        r_m_tvalid <= 1'b1;
                        r_m_tlast  <= 1'b0;
                        r_state    <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_beat) begin
                        r_m_tdata <= r_data[31:0];
                        r_state   <= ST_W0;
                    end
                end
                ST_W0: begin
                    if (w_beat) begin
                        r_m_tdata <= r_data[63:32];
                        r_state   <= ST_W1;
                    end
                end
                ST_W1: begin
                    if (w_beat) begin
                        r_m_tdata <= r_data[95:64];
                        r_m_tlast <= 1'b1;
                        r_state   <= ST_W2;
                    end
                end
                ST_W2: begin
                    if (w_beat) begin
                        r_m_tdata  <= '0;
                        r_m_tvalid <= 1'b0;
                        r_m_tlast  <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_m_tdata  <= '0;
                    r_m_tvalid <= 1'b0;
                    r_m_tlast  <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign s0_tready = w_tready[0];
    assign s1_tready = w_tready[1];
    assign m_tdata   = r_m_tdata;
    assign m_tvalid  = r_m_tvalid;
    assign m_tlast   = r_m_tlast;
    assign busy_o    = ~w_idle;

endmodule

// File: tb/tb_udma_ptp_ts_arb.sv
// ---------------------------------------------------------------------------
// tb_udma_ptp_ts_arb
// Directed self-checking bench for udma_ptp_ts_arb.
// ---------------------------------------------------------------------------
module tb_udma_ptp_ts_arb;

    logic        clk_eth;
    logic        rst_eth;
    logic [1:0]  cfg_src_en_i;
    logic [95:0] s0_tdata;
    logic        s0_tvalid;
    logic        s0_tready;
    logic [95:0] s1_tdata;
    logic        s1_tvalid;
    logic        s1_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy_o;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [95:0] D0 = 96'h333333332222222211111111;
    localparam logic [95:0] D1 = 96'hCCCCCCCCBBBBBBBBAAAAAAAA;
    localparam logic [95:0] D2 = 96'h0BADF00D_DEADBEEF_01234567;

    udma_ptp_ts_arb #(.MAGIC(8'hA5)) dut (
        .clk_eth      (clk_eth),
        .rst_eth      (rst_eth),
        .cfg_src_en_i (cfg_src_en_i),
        .s0_tdata     (s0_tdata),
        .s0_tvalid    (s0_tvalid),
        .s0_tready    (s0_tready),
        .s1_tdata     (s1_tdata),
        .s1_tvalid    (s1_tvalid),
        .s1_tready    (s1_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .busy_o       (busy_o)
    );

    initial clk_eth = 1'b0;
    always #5 clk_eth = ~clk_eth;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_eth);
        #1;
    endtask

    // Receive one 4-beat record, optionally toggling m_tready each cycle.
    // Checks every beat value, tlast position and stability while stalled.
    task automatic rx_record(input string tag, input bit toggle,
                             input logic [31:0] exp_hdr, input logic [95:0] exp_data);
        logic [31:0] exp_w [4];
        logic [31:0] prev_d;
        bit          prev_stall;
        int          nb;
        int          cyc;
        exp_w[0]   = exp_hdr;
        exp_w[1]   = exp_data[31:0];
        exp_w[2]   = exp_data[63:32];
        exp_w[3]   = exp_data[95:64];
        prev_stall = 1'b0;
        prev_d     = '0;
        nb         = 0;
        cyc        = 0;
        while (nb < 4 && cyc < 40) begin
            m_tready = toggle ? cyc[0] : 1'b1;
            if (m_tvalid) begin
                if (prev_stall)
                    chk($sformatf("%s_stable%0d", tag, nb), m_tdata, prev_d);
                if (m_tready) begin
                    chk($sformatf("%s_beat%0d", tag, nb), m_tdata, exp_w[nb]);
                    chk($sformatf("%s_last%0d", tag, nb), 32'(m_tlast), (nb == 3) ? 32'd1 : 32'd0);
                    nb++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_d     = m_tdata;
                end
            end
            step();
            cyc++;
        end
        if (nb < 4)
            chk($sformatf("%s_timeout_beats", tag), 32'(nb), 32'd4);
        m_tready = 1'b1;
        $display("rec %s hdr=%h beats=%0d", tag, exp_hdr, nb);
    endtask

    initial begin
        rst_eth      = 1'b1;
        cfg_src_en_i = 2'b11;
        s0_tdata     = D0;
        s1_tdata     = D1;
        s0_tvalid    = 1'b1;
        s1_tvalid    = 1'b1;
        m_tready     = 1'b1;

        // Reset: all outputs low even with both sources valid
        step(); step();
        chk("rst_s0_tready", 32'(s0_tready), 32'd0);
        chk("rst_s1_tready", 32'(s1_tready), 32'd0);
        chk("rst_m_tvalid",  32'(m_tvalid),  32'd0);
        chk("rst_m_tlast",   32'(m_tlast),   32'd0);
        chk("rst_busy",      32'(busy_o),    32'd0);
        chk("rst_m_tdata",   m_tdata,        32'h0);
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        rst_eth   = 1'b0;
        step();
        chk("idle_m_tvalid", 32'(m_tvalid), 32'd0);

        // Single src0 record, header one cycle after accept
        s0_tvalid = 1'b1;
        #0;
        chk("a_s0_tready", 32'(s0_tready), 32'd1);
        step();
        s0_tvalid = 1'b0;
        chk("a_m_tvalid_n1", 32'(m_tvalid), 32'd1);
        chk("a_busy_n1",     32'(busy_o),   32'd1);
        chk("a_s0_tready_held", 32'(s0_tready), 32'd0);
        rx_record("a", 1'b0, 32'hA500_0000, D0);
        chk("a_m_tvalid_end", 32'(m_tvalid), 32'd0);
        chk("a_busy_end",     32'(busy_o),   32'd0);

        // Round robin with both sources continuously valid
        rst_eth = 1'b1;
        step();
        rst_eth   = 1'b0;
        s0_tvalid = 1'b1;
        s1_tvalid = 1'b1;
        rx_record("rr0", 1'b0, 32'hA500_0000, D0);
        rx_record("rr1", 1'b0, 32'hA500_8000, D1);
        rx_record("rr2", 1'b0, 32'hA500_0001, D0);
        rx_record("rr3", 1'b0, 32'hA500_8001, D1);
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        step();
        chk("rr_idle_tvalid", 32'(m_tvalid), 32'd0);

        // Backpressure: m_tready toggles every cycle (src1 seq 2)
        s1_tdata  = D2;
        s1_tvalid = 1'b1;
        step();
        s1_tvalid = 1'b0;
        rx_record("bp", 1'b1, 32'hA500_8002, D2);

        // Only src1 enabled with both valid: src1 twice, src0 never ready
        cfg_src_en_i = 2'b10;
        s1_tdata     = D1;
        s0_tvalid    = 1'b1;
        s1_tvalid    = 1'b1;
        #0;
        chk("dis_s0_tready", 32'(s0_tready), 32'd0);
        chk("dis_s1_tready", 32'(s1_tready), 32'd1);
        rx_record("dis0", 1'b0, 32'hA500_8003, D1);
        chk("dis_s0_tready2", 32'(s0_tready), 32'd0);
        rx_record("dis1", 1'b0, 32'hA500_8004, D1);
        s0_tvalid    = 1'b0;
        s1_tvalid    = 1'b0;
        cfg_src_en_i = 2'b11;
        step();

        // src0 counter held at 2; disabling mid-record does not abort it
        s0_tvalid = 1'b1;
        step();
        s0_tvalid    = 1'b0;
        cfg_src_en_i = 2'b00;
        rx_record("held", 1'b0, 32'hA500_0002, D0);
        cfg_src_en_i = 2'b11;

        // Sequence wrap: 257 src1 records after reset
        rst_eth = 1'b1;
        step();
        rst_eth   = 1'b0;
        s1_tvalid = 1'b1;
        for (int k = 0; k < 257; k++) begin
            rx_record($sformatf("wrap%0d", k), 1'b0, 32'hA500_8000 | 32'(k[7:0]), D1);
        end
        s1_tvalid = 1'b0;
        step();

        // Reset during W1 discards the record; then src0 priority, seq 0
        s0_tvalid = 1'b1;
        step();
        s0_tvalid = 1'b0;
        chk("r35_hdr", m_tdata, 32'hA500_0000);
        step();
        step();
        chk("r35_w1_data", m_tdata, 32'h2222_2222);
        rst_eth   = 1'b1;
        s0_tvalid = 1'b1;
        s1_tvalid = 1'b1;
        step();
        chk("r35_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("r35_m_tlast",  32'(m_tlast),  32'd0);
        chk("r35_busy",     32'(busy_o),   32'd0);
        chk("r35_m_tdata",  m_tdata,       32'h0);
        chk("r35_s0_tready", 32'(s0_tready), 32'd0);
        rst_eth = 1'b0;
        rx_record("r35_after", 1'b0, 32'hA500_0000, D0);
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
